// File: rtl/frame_ctrl_pkg.sv
// Shared types and defaults for the serial frame controller.
// Optional feature macro: FRAME_CTRL_PARITY_EN (adds the PARITY state).
package frame_ctrl_pkg;

  localparam int unsigned AddrWDefault = 2;
  localparam int unsigned LenWDefault  = 4;

  // Number of output channels addressed by an addr_w-bit field.
  function automatic int unsigned num_ch(input int unsigned addr_w);
    return 32'd1 << addr_w;
  endfunction

  function automatic int unsigned max_w(input int unsigned a, input int unsigned b);
    return (a > b) ? a : b;
  endfunction

  typedef enum logic [2:0] {
    StIdle,
    StAddr,
    StLen,
    StPayload,
`ifdef FRAME_CTRL_PARITY_EN
    StParity,
`endif
    StDone
  } state_e;

endpackage

// File: rtl/frame_ctrl_if.sv
// Handshake/bus bundle between the frame controller, the pattern detector and the sinks.
// parity_err exists only when FRAME_CTRL_PARITY_EN is defined.
interface frame_ctrl_if
  import frame_ctrl_pkg::*;
#(
  parameter int unsigned ADDR_W = AddrWDefault
);
  localparam int unsigned NUM_CH = num_ch(ADDR_W);

  logic              serial_in;
  logic              start;
  logic              busy;
  logic [ADDR_W-1:0] addr;
  logic              data_out;
  logic [NUM_CH-1:0] valid;
  logic              done;
  logic              get_back;
`ifdef FRAME_CTRL_PARITY_EN
  logic              parity_err;
`endif

  // Detector / stimulus side
  modport master (
    output serial_in, start,
    input  busy, addr, data_out, valid, done, get_back
`ifdef FRAME_CTRL_PARITY_EN
    , input parity_err
`endif
  );

  // Frame controller side
  modport slave (
    input  serial_in, start,
    output busy, addr, data_out, valid, done, get_back
`ifdef FRAME_CTRL_PARITY_EN
    , output parity_err
`endif
  );

endinterface

// File: rtl/frame_bit_counter.sv
// Loadable down-counter with a terminal-count flag (count == 1).
// Shared by the address, length and payload phases of frame_ctrl.
module frame_bit_counter #(
  parameter int unsigned Width = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             load_i,
  input  logic [Width-1:0] load_val_i,
  input  logic             dec_i,
  output logic             tc_o
);

  logic [Width-1:0] count_q, count_d;

  // Load has priority; decrement saturates at zero so the count never wraps.
  always_comb begin
    count_d = count_q;
    if (load_i) begin
      count_d = load_val_i;
    end else if (dec_i && (count_q != '0)) begin
      count_d = count_q - 1'b1;
    end
  end

  // Counter state register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  assign tc_o = (count_q == Width'(1));

endmodule

// File: rtl/frame_ctrl.sv
// Serial frame controller: after a detector wake pulse it shifts in an address and a length
// field (MSB first), then routes the payload bits to the addressed channel, one per cycle.
// Define FRAME_CTRL_PARITY_EN to add an even-parity bit after the payload and a sticky
// parity_err output.
module frame_ctrl
  import frame_ctrl_pkg::*;
#(
  parameter int unsigned ADDR_W = AddrWDefault,
  parameter int unsigned LEN_W  = LenWDefault
) (
  input logic         clk,
  input logic         rst_n,
  frame_ctrl_if.slave bus
);

  localparam int unsigned NUM_CH = num_ch(ADDR_W);
  localparam int unsigned CNT_W  = max_w(ADDR_W, LEN_W);

`ifdef FRAME_CTRL_PARITY_EN
  localparam state_e StAfterData = StParity;
`else
  localparam state_e StAfterData = StDone;
`endif

  state_e            state_q, state_d;
  logic [ADDR_W-1:0] addr_q;
  logic [LEN_W-1:0]  len_q;
  logic              data_q;
  logic [NUM_CH-1:0] valid_q;
  logic              done_q;
  logic              busy_q;
`ifdef FRAME_CTRL_PARITY_EN
  logic              par_q;
  logic              parity_err_q;
`endif

  logic              cnt_load;
  logic              cnt_dec;
  logic [CNT_W-1:0]  cnt_load_val;
  logic              cnt_tc;

  logic [ADDR_W-1:0] addr_shift;
  logic [LEN_W-1:0]  len_shift;

  // Field values including the bit currently on the line; the oldest bit falls off the top.
  assign addr_shift = ADDR_W'({addr_q, bus.serial_in});
  assign len_shift  = LEN_W'({len_q, bus.serial_in});

  frame_bit_counter #(
    .Width (CNT_W)
  ) u_bit_counter (
    .clk        (clk),
    .rst_n      (rst_n),
    .load_i     (cnt_load),
    .load_val_i (cnt_load_val),
    .dec_i      (cnt_dec),
    .tc_o       (cnt_tc)
  );

  // Next-state and bit-counter control.
  always_comb begin
    state_d      = state_q;
    cnt_load     = 1'b0;
    cnt_dec      = 1'b0;
    cnt_load_val = '0;
    unique case (state_q)
      StIdle: begin
        if (bus.start) begin
          state_d      = StAddr;
          cnt_load     = 1'b1;
          cnt_load_val = CNT_W'(ADDR_W);
        end
      end
      StAddr: begin
        if (cnt_tc) begin
          state_d      = StLen;
          cnt_load     = 1'b1;
          cnt_load_val = CNT_W'(LEN_W);
        end else begin
          cnt_dec = 1'b1;
        end
      end
      StLen: begin
        if (cnt_tc) begin
          if (len_shift == '0) begin
            state_d = StAfterData;
          end else begin
            state_d      = StPayload;
            cnt_load     = 1'b1;
            cnt_load_val = CNT_W'(len_shift);
          end
        end else begin
          cnt_dec = 1'b1;
        end
      end
      StPayload: begin
        if (cnt_tc) begin
          state_d = StAfterData;
        end else begin
          cnt_dec = 1'b1;
        end
      end
`ifdef FRAME_CTRL_PARITY_EN
      StParity: state_d = StDone;
`endif
      StDone:   state_d = StIdle;
      default:  state_d = StIdle;
    endcase
  end

  // State plus registered outputs; done/busy are derived from the state being entered.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= StIdle;
      addr_q       <= '0;
      len_q        <= '0;
      data_q       <= 1'b0;
      valid_q      <= '0;
      done_q       <= 1'b0;
      busy_q       <= 1'b0;
`ifdef FRAME_CTRL_PARITY_EN
      par_q        <= 1'b0;
      parity_err_q <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      busy_q  <= (state_d != StIdle);
      done_q  <= (state_d == StDone);
      valid_q <= '0;
`ifdef FRAME_CTRL_PARITY_EN
      if ((state_q == StIdle) && bus.start) begin
        par_q        <= 1'b0;
        parity_err_q <= 1'b0;
      end
      if ((state_q == StParity) && (par_q ^ bus.serial_in)) begin
        parity_err_q <= 1'b1;
      end
`endif
      if (state_q == StAddr) begin
        addr_q <= addr_shift;
      end
      if (state_q == StLen) begin
        len_q <= len_shift;
      end
      if (state_q == StPayload) begin
        data_q  <= bus.serial_in;
        valid_q <= NUM_CH'(1) << addr_q;
`ifdef FRAME_CTRL_PARITY_EN
        par_q   <= par_q ^ bus.serial_in;
`endif
      end
    end
  end

  assign bus.busy       = busy_q;
  assign bus.addr       = addr_q;
  assign bus.data_out   = data_q;
  assign bus.valid      = valid_q;
  assign bus.done       = done_q;
  assign bus.get_back   = done_q;
`ifdef FRAME_CTRL_PARITY_EN
  assign bus.parity_err = parity_err_q;
`endif

endmodule
